// File: rtl/local_traffic_unit.sv
// Local traffic endpoint: injects a programmed burst of single-flit packets and absorbs/counts ejected flits.
// Optional feature macro: LOCAL_TRAFFIC_SEQCHK_EN (per-port ejected sequence-number checking).
module local_traffic_unit #(
    parameter int cur_x     = 0,
    parameter int cur_y     = 0,
    parameter int cur_z     = 0,
    parameter int FLIT_SIZE = 82
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [15:0]          cfg_count,
    input  logic [7:0]           cfg_gap,
    input  logic [11:0]          cfg_dst,
    output logic                 busy,
    output logic                 done,
    output logic [FLIT_SIZE-1:0] inject_xpos,
    output logic                 inject_xpos_valid,
    output logic [FLIT_SIZE-1:0] inject_ypos,
    output logic                 inject_ypos_valid,
    input  logic [FLIT_SIZE-1:0] eject_xpos,
    input  logic                 eject_xpos_valid,
    input  logic [FLIT_SIZE-1:0] eject_ypos,
    input  logic                 eject_ypos_valid,
    output logic [15:0]          rx_count,
    output logic [15:0]          rx_err_count,
    output logic [FLIT_SIZE-1:0] rx_last
);

    localparam logic [11:0] CUR_DST = {4'(cur_x), 4'(cur_y), 4'(cur_z)};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt_r;
    logic [7:0]  gap_r;
    logic [11:0] dst_r;
    logic [15:0] seq_r;
    logic [7:0]  gap_cnt;
    logic        last_pkt;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {15'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign last_pkt = (seq_r == cnt_r - 16'd1);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_LOAD;
            S_LOAD: state_nxt = (cnt_r == 16'd0) ? S_DONE : S_SEND;
            S_SEND: begin
                if (last_pkt)            state_nxt = S_DONE;
                else if (gap_r == 8'd0)  state_nxt = S_SEND;
                else                     state_nxt = S_GAP;
            end
            S_GAP:  if (gap_cnt <= 8'd1) state_nxt = S_SEND;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Burst control: configuration is captured on the accepted start so later cfg changes are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt_r   <= '0;
            gap_r   <= '0;
            dst_r   <= '0;
            seq_r   <= '0;
            gap_cnt <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt_r <= cfg_count;
                        gap_r <= cfg_gap;
                        dst_r <= cfg_dst;
                        seq_r <= '0;
                    end
                end
                S_SEND: begin
                    seq_r   <= seq_r + 16'd1;
                    gap_cnt <= gap_r;
                end
                S_GAP:  gap_cnt <= gap_cnt - 8'd1;
                default: ;
            endcase
        end
    end

    logic        sending;
    logic        sel_x;
    logic [81:0] tx_flit;

    assign sending = (state == S_SEND);
    assign sel_x   = (dst_r[11:8] != CUR_DST[11:8]);
    assign tx_flit = {dst_r, CUR_DST, seq_r, 26'b0, seq_r};

    // Outputs decode straight from the state register, so an async reset drops the valids at once
    assign busy              = (state != S_IDLE) && (state != S_DONE);
    assign done              = (state == S_DONE);
    assign inject_xpos_valid = sending && sel_x;
    assign inject_ypos_valid = sending && !sel_x;
    assign inject_xpos       = inject_xpos_valid ? FLIT_SIZE'(tx_flit) : '0;
    assign inject_ypos       = inject_ypos_valid ? FLIT_SIZE'(tx_flit) : '0;

    logic seq_bad_x, seq_bad_y;
    logic err_x, err_y;
    logic [1:0] rx_inc, err_inc;

`ifdef LOCAL_TRAFFIC_SEQCHK_EN
    logic [15:0] exp_seq_x, exp_seq_y;

    assign seq_bad_x = (eject_xpos[57:42] != exp_seq_x);
    assign seq_bad_y = (eject_ypos[57:42] != exp_seq_y);

    // Expected sequence follows the last received flit, so one gap costs one error and then resyncs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_seq_x <= '0;
            exp_seq_y <= '0;
        end else begin
            if (eject_xpos_valid) exp_seq_x <= eject_xpos[57:42] + 16'd1;
            if (eject_ypos_valid) exp_seq_y <= eject_ypos[57:42] + 16'd1;
        end
    end
`else
    assign seq_bad_x = 1'b0;
    assign seq_bad_y = 1'b0;
`endif

    assign err_x   = eject_xpos_valid && ((eject_xpos[81:70] != CUR_DST) || seq_bad_x);
    assign err_y   = eject_ypos_valid && ((eject_ypos[81:70] != CUR_DST) || seq_bad_y);
    assign rx_inc  = {1'b0, eject_xpos_valid} + {1'b0, eject_ypos_valid};
    assign err_inc = {1'b0, err_x} + {1'b0, err_y};

    // Eject stage: one-cycle registered update, ypos wins rx_last when both ports fire
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_count     <= '0;
            rx_err_count <= '0;
            rx_last      <= '0;
        end else begin
            rx_count     <= sat_add16(rx_count, rx_inc);
            rx_err_count <= sat_add16(rx_err_count, err_inc);
            if (eject_ypos_valid)      rx_last <= eject_ypos;
            else if (eject_xpos_valid) rx_last <= eject_xpos;
        end
    end

endmodule

// File: tb/tb_local_traffic_unit.sv
// Directed self-checking bench for local_traffic_unit at node (0,0,0).
module tb_local_traffic_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] cfg_count;
    logic [7:0]  cfg_gap;
    logic [11:0] cfg_dst;
    logic        busy, done;
    logic [81:0] inject_xpos, inject_ypos;
    logic        inject_xpos_valid, inject_ypos_valid;
    logic [81:0] eject_xpos, eject_ypos;
    logic        eject_xpos_valid, eject_ypos_valid;
    logic [15:0] rx_count, rx_err_count;
    logic [81:0] rx_last;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    local_traffic_unit dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_count(cfg_count), .cfg_gap(cfg_gap), .cfg_dst(cfg_dst),
        .busy(busy), .done(done),
        .inject_xpos(inject_xpos), .inject_xpos_valid(inject_xpos_valid),
        .inject_ypos(inject_ypos), .inject_ypos_valid(inject_ypos_valid),
        .eject_xpos(eject_xpos), .eject_xpos_valid(eject_xpos_valid),
        .eject_ypos(eject_ypos), .eject_ypos_valid(eject_ypos_valid),
        .rx_count(rx_count), .rx_err_count(rx_err_count), .rx_last(rx_last)
    );

    function automatic logic [81:0] mk_flit(input logic [11:0] dst, input logic [11:0] src,
                                            input logic [15:0] seq);
        return {dst, src, seq, 26'b0, seq};
    endfunction

    task automatic chk(input string tag, input logic [81:0] obs, input logic [81:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [81:0] good_f, bad_f;

    initial begin
        rst = 1'b1; start = 1'b0;
        cfg_count = '0; cfg_gap = '0; cfg_dst = '0;
        eject_xpos = '0; eject_ypos = '0;
        eject_xpos_valid = 1'b0; eject_ypos_valid = 1'b0;
        tick(); tick();

        // reset state
        chk("rst_busy", 82'(busy), 82'd0);
        chk("rst_done", 82'(done), 82'd0);
        chk("rst_xv", 82'(inject_xpos_valid), 82'd0);
        chk("rst_yv", 82'(inject_ypos_valid), 82'd0);
        chk("rst_rxc", 82'(rx_count), 82'd0);
        chk("rst_rxe", 82'(rx_err_count), 82'd0);
        chk("rst_last", rx_last, 82'd0);
        rst = 1'b0;
        tick();

        // T2: dst (1,0,0), 3 packets, gap 2 -> xpos at +2,+5,+8, done at +9
        cfg_dst = 12'h100; cfg_count = 16'd3; cfg_gap = 8'd2; start = 1'b1;
        tick(); start = 1'b0;
        chk("t2_busy1", 82'(busy), 82'd1);
        for (int c = 2; c <= 10; c++) begin
            tick();
            chk($sformatf("t2_xv_c%0d", c), 82'(inject_xpos_valid), 82'(c == 2 || c == 5 || c == 8));
            chk($sformatf("t2_yv_c%0d", c), 82'(inject_ypos_valid), 82'd0);
            chk($sformatf("t2_done_c%0d", c), 82'(done), 82'(c == 9));
            if (c == 2 || c == 5 || c == 8)
                chk($sformatf("t2_flit_c%0d", c), inject_xpos, mk_flit(12'h100, 12'h000, 16'((c - 2) / 3)));
            chk($sformatf("t2_ydata_c%0d", c), inject_ypos, 82'd0);
        end
        chk("t2_idle_busy", 82'(busy), 82'd0);

        // T3: dst (0,2,0), 2 packets back-to-back on ypos; cfg change mid-burst has no effect
        cfg_dst = 12'h020; cfg_count = 16'd2; cfg_gap = 8'd0; start = 1'b1;
        tick(); start = 1'b0;
        cfg_dst = 12'h100; cfg_count = 16'd9; cfg_gap = 8'd5;
        for (int c = 2; c <= 5; c++) begin
            tick();
            chk($sformatf("t3_yv_c%0d", c), 82'(inject_ypos_valid), 82'(c == 2 || c == 3));
            chk($sformatf("t3_xv_c%0d", c), 82'(inject_xpos_valid), 82'd0);
            chk($sformatf("t3_done_c%0d", c), 82'(done), 82'(c == 4));
            if (c == 2 || c == 3)
                chk($sformatf("t3_flit_c%0d", c), inject_ypos, mk_flit(12'h020, 12'h000, 16'(c - 2)));
        end

        // T5: count 0 -> done two cycles after start, no injection
        cfg_dst = 12'h100; cfg_count = 16'd0; cfg_gap = 8'd1; start = 1'b1;
        tick(); start = 1'b0;
        chk("t5_xv_c1", 82'(inject_xpos_valid), 82'd0);
        chk("t5_done_c1", 82'(done), 82'd0);
        tick();
        chk("t5_done_c2", 82'(done), 82'd1);
        chk("t5_xv_c2", 82'(inject_xpos_valid | inject_ypos_valid), 82'd0);
        tick();
        chk("t5_done_c3", 82'(done), 82'd0);

        // T1: counters nonzero, then rst during GAP of a 5-packet burst
        eject_xpos = mk_flit(12'h000, 12'h123, 16'd0); eject_xpos_valid = 1'b1;
        tick(); eject_xpos_valid = 1'b0;
        chk("t1_pre_rxc", 82'(rx_count), 82'd1);
        cfg_dst = 12'h100; cfg_count = 16'd5; cfg_gap = 8'd3; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        chk("t1_send", 82'(inject_xpos_valid), 82'd1);
        tick();
        chk("t1_gap", 82'(inject_xpos_valid), 82'd0);
        rst = 1'b1;
        #1;
        chk("t1_async_busy", 82'(busy), 82'd0);
        tick();
        chk("t1_xv", 82'(inject_xpos_valid), 82'd0);
        chk("t1_busy", 82'(busy), 82'd0);
        chk("t1_rxc", 82'(rx_count), 82'd0);
        chk("t1_rxe", 82'(rx_err_count), 82'd0);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("t1_nodone_%0d", c), 82'(done | inject_xpos_valid | busy), 82'd0);
        end

        // T4: good xpos flit and bad-dst ypos flit in the same cycle
        good_f = mk_flit(12'h000, 12'h123, 16'd0);
        bad_f  = mk_flit(12'h333, 12'h456, 16'd0);
        eject_xpos = good_f; eject_xpos_valid = 1'b1;
        eject_ypos = bad_f;  eject_ypos_valid = 1'b1;
        tick();
        eject_xpos_valid = 1'b0; eject_ypos_valid = 1'b0;
        chk("t4_rxc", 82'(rx_count), 82'd2);
        chk("t4_rxe", 82'(rx_err_count), 82'd1);
        chk("t4_last", rx_last, bad_f);
        tick();
        chk("t4_hold", 82'(rx_count), 82'd2);

        // T7: xpos seq 0,1,3 then 4, all with correct dst
        pulse_rst();
        for (int i = 0; i < 4; i++) begin
            eject_xpos = mk_flit(12'h000, 12'h111, (i == 0) ? 16'd0 : (i == 1) ? 16'd1 : (i == 2) ? 16'd3 : 16'd4);
            eject_xpos_valid = 1'b1;
            tick();
            eject_xpos_valid = 1'b0;
            if (i == 2) begin
`ifdef LOCAL_TRAFFIC_SEQCHK_EN
                chk("t7_gap_err", 82'(rx_err_count), 82'd1);
`else
                chk("t7_gap_err", 82'(rx_err_count), 82'd0);
`endif
            end
        end
`ifdef LOCAL_TRAFFIC_SEQCHK_EN
        chk("t7_resync", 82'(rx_err_count), 82'd1);
`else
        chk("t7_resync", 82'(rx_err_count), 82'd0);
`endif
        chk("t7_rxc", 82'(rx_count), 82'd4);
        chk("t7_last", rx_last, mk_flit(12'h000, 12'h111, 16'd4));

        // T6: drive both ports with bad flits to reach 16'hFFFE, then 3 more flits saturate
        pulse_rst();
        eject_xpos = bad_f; eject_ypos = bad_f;
        eject_xpos_valid = 1'b1; eject_ypos_valid = 1'b1;
        for (int i = 0; i < 32767; i++) tick();
        eject_xpos_valid = 1'b0; eject_ypos_valid = 1'b0;
        chk("t6_pre_rxc", 82'(rx_count), 82'hFFFE);
        chk("t6_pre_rxe", 82'(rx_err_count), 82'hFFFE);
        eject_xpos_valid = 1'b1; eject_ypos_valid = 1'b1;
        tick();
        eject_ypos_valid = 1'b0;
        chk("t6_sat1", 82'(rx_count), 82'hFFFF);
        tick();
        eject_xpos_valid = 1'b0;
        chk("t6_sat_rxc", 82'(rx_count), 82'hFFFF);
        chk("t6_sat_rxe", 82'(rx_err_count), 82'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
